// File: rtl/color_pkg.sv
// Shared colour and turn-state types for the detector, the vote manager and the game FSM.
package color_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BLUE  = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    WHITE  = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    HELD   = 2'd3
  } state_t;

  localparam int CONF_W = 16;
  localparam int CNT_W  = 4;
  localparam int SUM_W  = 20;

endpackage

// File: rtl/color_vote_window.sv
// Sliding history of per-frame colour decisions with incremental per-colour
// vote counters and confidence sums, plus the combinational winner pick.
module color_vote_window
  import color_pkg::*;
#(
  parameter int VOTE_DEPTH  = 5,
  parameter int VOTE_THRESH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              clear,
  input  color_t            entry_color,
  input  logic [CONF_W-1:0] entry_conf,
  output color_t            winner,
  output logic [CNT_W-1:0]  votes,
  output logic [SUM_W-1:0]  conf_sum
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(VOTE_THRESH);

  color_t            hist_color [VOTE_DEPTH];
  logic [CONF_W-1:0] hist_conf  [VOTE_DEPTH];
  // Indexed by colour code; slot 0 tracks NONE entries and is never a candidate.
  logic [CNT_W-1:0]  cnt        [4];
  logic [SUM_W-1:0]  sum        [4];

  color_t            evict_color;
  logic [CONF_W-1:0] evict_conf;

  assign evict_color = hist_color[VOTE_DEPTH-1];
  assign evict_conf  = hist_conf[VOTE_DEPTH-1];

  // Shift the history on each push and adjust counters by (new in) - (oldest out).
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < VOTE_DEPTH; i++) begin
        hist_color[i] <= NONE;
        hist_conf[i]  <= '0;
      end
      for (int c = 0; c < 4; c++) begin
        cnt[c] <= '0;
        sum[c] <= '0;
      end
    end else if (push) begin
      hist_color[0] <= entry_color;
      hist_conf[0]  <= entry_conf;
      for (int i = 1; i < VOTE_DEPTH; i++) begin
        hist_color[i] <= hist_color[i-1];
        hist_conf[i]  <= hist_conf[i-1];
      end
      for (int c = 0; c < 4; c++) begin
        cnt[c] <= cnt[c]
                  + {3'b000, (entry_color == color_t'(2'(c)))}
                  - {3'b000, (evict_color == color_t'(2'(c)))};
        sum[c] <= sum[c]
                  + ((entry_color == color_t'(2'(c))) ? {4'b0000, entry_conf} : '0)
                  - ((evict_color == color_t'(2'(c))) ? {4'b0000, evict_conf} : '0);
      end
    end
  end

  // Winner is the first colour in RED, GREEN, BLUE order that meets the threshold.
  always_comb begin
    winner   = NONE;
    votes    = '0;
    conf_sum = '0;
    if (cnt[1] >= THRESH) begin
      winner   = RED;
      votes    = cnt[1];
      conf_sum = sum[1];
    end else if (cnt[2] >= THRESH) begin
      winner   = GREEN;
      votes    = cnt[2];
      conf_sum = sum[2];
    end else if (cnt[3] >= THRESH) begin
      winner   = BLUE;
      votes    = cnt[3];
      conf_sum = sum[3];
    end
  end

endmodule

// File: rtl/color_vote_manager.sv
// Turn manager between the ROI colour detector and the game FSM: votes over a
// frame window, locks one colour per turn behind a valid/ack handshake, and
// returns to idle after a run of white frames or a frame timeout.
//
// Handshake: result_valid is a level that rises when a colour locks and stays
// high until the first cycle result_ack is seen high with it; it then falls on
// the next cycle. result_ack is ignored whenever result_valid is low.
module color_vote_manager
  import color_pkg::*;
#(
  parameter int          VOTE_DEPTH        = 5,
  parameter int          VOTE_THRESH       = 3,
  parameter logic [15:0] MIN_CONFIDENCE    = 16'd100,
  parameter int          WHITE_FRAME_COUNT = 3,
  parameter int          TIMEOUT_FRAMES    = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  detected_color,
  input  logic        color_valid,
  input  logic [15:0] color_confidence,
  input  logic        white_detected,
  output logic [1:0]  result_color,
  output logic        result_valid,
  input  logic        result_ack,
  output logic [3:0]  result_votes,
  output logic [19:0] result_conf_sum,
  output logic        turn_end,
  output logic        turn_abort,
  output logic        idle_white
);

  localparam logic [4:0]  WHITE_RUN = 5'(WHITE_FRAME_COUNT);
  localparam logic [15:0] TIMEOUT   = 16'(TIMEOUT_FRAMES);

  state_t       state;
  state_t       next_state;
  color_t       entry_color;
  color_t       win_color;
  logic [3:0]   win_votes;
  logic [19:0]  win_sum;
  logic [3:0]   white_run;
  logic [15:0]  frame_cnt;
  logic         push;
  logic         entry_hit;
  logic         white_done;
  logic         timeout_hit;
  logic         clear_hist;
  logic         do_lock;
  logic         do_abort;
  logic         do_end;

  // A coincident white frame takes precedence and suppresses the colour push.
  assign entry_color = (color_confidence < MIN_CONFIDENCE) ? NONE : color_t'(detected_color);
  assign push        = color_valid & ~white_detected;
  assign entry_hit   = push && (entry_color != NONE);
  assign white_done  = white_detected && (state != WHITE) &&
                       (({1'b0, white_run} + 5'd1) >= WHITE_RUN);
  assign timeout_hit = (TIMEOUT_FRAMES != 0) && (frame_cnt >= TIMEOUT);
  assign clear_hist  = (state != WHITE) && (next_state == WHITE);

  color_vote_window #(
    .VOTE_DEPTH  (VOTE_DEPTH),
    .VOTE_THRESH (VOTE_THRESH)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .clear       (clear_hist),
    .entry_color (entry_color),
    .entry_conf  (color_confidence),
    .winner      (win_color),
    .votes       (win_votes),
    .conf_sum    (win_sum)
  );

  // Turn state register.
  always_ff @(posedge clk) begin
    if (reset) state <= WHITE;
    else       state <= next_state;
  end

  // Next-state decision; a finished white run outranks lock, ack and timeout.
  always_comb begin
    next_state = state;
    do_lock    = 1'b0;
    do_abort   = 1'b0;
    do_end     = 1'b0;
    unique case (state)
      WHITE: begin
        if (entry_hit) next_state = ARMED;
      end
      ARMED: begin
        if (white_done) begin
          next_state = WHITE;
        end else if (win_color != NONE) begin
          next_state = LOCKED;
          do_lock    = 1'b1;
        end else if (timeout_hit) begin
          next_state = WHITE;
          do_abort   = 1'b1;
        end
      end
      LOCKED: begin
        if (white_done) begin
          next_state = WHITE;
          do_end     = 1'b1;
        end else if (result_ack) begin
          next_state = HELD;
        end
      end
      HELD: begin
        if (white_done) begin
          next_state = WHITE;
          do_end     = 1'b1;
        end
      end
      default: next_state = WHITE;
    endcase
  end

  // Level outputs decoded directly from the turn state.
  always_comb begin
    result_valid = (state == LOCKED);
    idle_white   = (state == WHITE);
  end

  // White run and timeout frame counters; the arming frame counts as frame one.
  always_ff @(posedge clk) begin
    if (reset) begin
      white_run <= '0;
      frame_cnt <= '0;
    end else begin
      if (state == WHITE || clear_hist) white_run <= '0;
      else if (white_detected)          white_run <= white_run + 4'd1;
      else if (entry_hit)               white_run <= '0;

      if (state == WHITE && entry_hit)                        frame_cnt <= 16'd1;
      else if (state == ARMED && push && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Latched result fields and the one-cycle turn pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_color    <= '0;
      result_votes    <= '0;
      result_conf_sum <= '0;
      turn_end        <= 1'b0;
      turn_abort      <= 1'b0;
    end else begin
      turn_end   <= do_end;
      turn_abort <= do_abort;
      if (do_lock) begin
        result_color    <= win_color;
        result_votes    <= win_votes;
        result_conf_sum <= win_sum;
      end else if (clear_hist) begin
        result_color    <= '0;
        result_votes    <= '0;
        result_conf_sum <= '0;
      end
    end
  end

endmodule

// File: tb/tb_color_vote_manager.sv
// Self-checking bench for color_vote_manager: hand-computed vector table,
// directed corner sequences, and randomized traffic against a queue-based model.
module tb_color_vote_manager;

  localparam int DEPTH  = 5;
  localparam int THRESH = 3;
  localparam int MINC   = 100;
  localparam int WFC    = 3;
  localparam int TOUT   = 60;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  detected_color = '0;
  logic        color_valid = 1'b0;
  logic [15:0] color_confidence = '0;
  logic        white_detected = 1'b0;
  logic        result_ack = 1'b0;
  logic [1:0]  result_color;
  logic        result_valid;
  logic [3:0]  result_votes;
  logic [19:0] result_conf_sum;
  logic        turn_end;
  logic        turn_abort;
  logic        idle_white;

  always #5 clk = ~clk;

  color_vote_manager #(
    .VOTE_DEPTH        (DEPTH),
    .VOTE_THRESH       (THRESH),
    .MIN_CONFIDENCE    (16'(MINC)),
    .WHITE_FRAME_COUNT (WFC),
    .TIMEOUT_FRAMES    (TOUT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .detected_color   (detected_color),
    .color_valid      (color_valid),
    .color_confidence (color_confidence),
    .white_detected   (white_detected),
    .result_color     (result_color),
    .result_valid     (result_valid),
    .result_ack       (result_ack),
    .result_votes     (result_votes),
    .result_conf_sum  (result_conf_sum),
    .turn_end         (turn_end),
    .turn_abort       (turn_abort),
    .idle_white       (idle_white)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Window kept as a queue of the most recent entries (newest first);
  // votes are recounted from scratch each cycle.
  int m_hc[$];
  int m_hf[$];
  int m_st = 0;   // 0 white, 1 armed, 2 locked, 3 held
  int m_wrun = 0, m_frames = 0;
  int m_color = 0, m_votes = 0, m_sum = 0;
  int m_valid = 0, m_end = 0, m_abort = 0, m_idle = 1;

  function automatic void model_winner(output int c, output int v, output int s);
    c = 0; v = 0; s = 0;
    for (int col = 1; col <= 3; col++) begin
      int n = 0;
      int sm = 0;
      foreach (m_hc[i]) if (m_hc[i] == col) begin n++; sm += m_hf[i]; end
      if (c == 0 && n >= THRESH) begin c = col; v = n; s = sm; end
    end
  endfunction

  task automatic model_step(input bit rst, input bit cv, input int col, input int conf,
                            input bit wd, input bit ack);
    int wc, wv, ws, nxt, ent;
    bit push, hit, wdone, lock, entering;
    if (rst) begin
      m_hc.delete(); m_hf.delete();
      m_st = 0; m_wrun = 0; m_frames = 0;
      m_color = 0; m_votes = 0; m_sum = 0;
      m_valid = 0; m_end = 0; m_abort = 0; m_idle = 1;
      return;
    end
    model_winner(wc, wv, ws);
    push  = cv && !wd;
    ent   = (conf < MINC) ? 0 : col;
    hit   = push && ent != 0;
    wdone = wd && m_st != 0 && (m_wrun + 1 >= WFC);
    nxt = m_st; lock = 0; m_end = 0; m_abort = 0;
    case (m_st)
      0: if (hit) nxt = 1;
      1: if (wdone) nxt = 0;
         else if (wc != 0) begin nxt = 2; lock = 1; end
         else if (TOUT > 0 && m_frames >= TOUT) begin nxt = 0; m_abort = 1; end
      2: if (wdone) begin nxt = 0; m_end = 1; end else if (ack) nxt = 3;
      default: if (wdone) begin nxt = 0; m_end = 1; end
    endcase
    entering = (m_st != 0 && nxt == 0);
    if (entering) begin
      m_hc.delete(); m_hf.delete();
    end else if (push) begin
      m_hc.push_front(ent); m_hf.push_front(conf);
      if (m_hc.size() > DEPTH) begin void'(m_hc.pop_back()); void'(m_hf.pop_back()); end
    end
    if (m_st == 0 && hit) m_frames = 1;
    else if (m_st == 1 && push && m_frames < 65535) m_frames++;
    if (m_st == 0 || entering) m_wrun = 0;
    else if (wd) m_wrun++;
    else if (hit) m_wrun = 0;
    if (lock) begin m_color = wc; m_votes = wv; m_sum = ws; end
    else if (entering) begin m_color = 0; m_votes = 0; m_sum = 0; end
    m_st = nxt;
    m_valid = (nxt == 2);
    m_idle  = (nxt == 0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, int'(result_valid), m_valid);
    check({tag, ".color"}, int'(result_color), m_color);
    check({tag, ".votes"}, int'(result_votes), m_votes);
    check({tag, ".sum"},   int'(result_conf_sum), m_sum);
    check({tag, ".end"},   int'(turn_end), m_end);
    check({tag, ".abort"}, int'(turn_abort), m_abort);
    check({tag, ".idle"},  int'(idle_white), m_idle);
  endtask

  // ---------------- driver ----------------
  // Called just after an active edge; drives one cycle and checks after the next edge.
  task automatic drive(input bit rst, input bit cv, input int col, input int conf,
                       input bit wd, input bit ack, input string tag);
    reset            = rst;
    color_valid      = cv;
    detected_color   = 2'(col);
    color_confidence = 16'(conf);
    white_detected   = wd;
    result_ack       = ack;
    model_step(rst, cv, col, conf, wd, ack);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic idle_cycle(input string tag);
    drive(0, 0, 0, 0, 0, 0, tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit cv; int col; int conf; bit wd; bit ack;
    int valid; int color; int votes; int sum; int te; int ta; int idle;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input bit cv, input int col, input int conf, input bit wd, input bit ack,
                         input int valid, input int color, input int votes, input int sum,
                         input int te, input int ta, input int idle);
    vec_t v;
    v.cv = cv; v.col = col; v.conf = conf; v.wd = wd; v.ack = ack;
    v.valid = valid; v.color = color; v.votes = votes; v.sum = sum;
    v.te = te; v.ta = ta; v.idle = idle;
    tbl.push_back(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // RED x3 @200 locks two cycles after the third push; ack; white run ends turn.
    add_vec(1,1,200,0,0, 0,0,0,0,   0,0,0);
    add_vec(1,1,200,0,0, 0,0,0,0,   0,0,0);
    add_vec(1,1,200,0,0, 0,0,0,0,   0,0,0);
    add_vec(0,0,0,0,0,   1,1,3,600, 0,0,0);
    add_vec(0,0,0,0,1,   0,1,3,600, 0,0,0);
    add_vec(0,0,0,1,0,   0,1,3,600, 0,0,0);
    add_vec(0,0,0,1,0,   0,1,3,600, 0,0,0);
    add_vec(0,0,0,1,0,   0,0,0,0,   1,0,1);
    // BLUE with mixed confidences, never acked; white run discards it; late ack inert.
    add_vec(1,3,300,0,0, 0,0,0,0,    0,0,0);
    add_vec(1,3,400,0,0, 0,0,0,0,    0,0,0);
    add_vec(1,3,500,0,0, 0,0,0,0,    0,0,0);
    add_vec(0,0,0,0,0,   1,3,3,1200, 0,0,0);
    add_vec(0,0,0,1,0,   1,3,3,1200, 0,0,0);
    add_vec(0,0,0,1,0,   1,3,3,1200, 0,0,0);
    add_vec(0,0,0,1,0,   0,0,0,0,    1,0,1);
    add_vec(0,0,0,0,1,   0,0,0,0,    0,0,1);
    // GREEN; ack; two whites, a colour frame restarts the run, three whites end it.
    add_vec(1,2,200,0,0, 0,0,0,0,   0,0,0);
    add_vec(1,2,200,0,0, 0,0,0,0,   0,0,0);
    add_vec(1,2,200,0,0, 0,0,0,0,   0,0,0);
    add_vec(0,0,0,0,0,   1,2,3,600, 0,0,0);
    add_vec(0,0,0,0,1,   0,2,3,600, 0,0,0);
    add_vec(0,0,0,1,0,   0,2,3,600, 0,0,0);
    add_vec(0,0,0,1,0,   0,2,3,600, 0,0,0);
    add_vec(1,1,200,0,0, 0,2,3,600, 0,0,0);
    add_vec(0,0,0,1,0,   0,2,3,600, 0,0,0);
    add_vec(0,0,0,1,0,   0,2,3,600, 0,0,0);
    add_vec(0,0,0,1,0,   0,0,0,0,   1,0,1);
    add_vec(0,0,0,0,0,   0,0,0,0,   0,0,1);

    // Reset state.
    drive(1, 0, 0, 0, 0, 0, "reset0");
    drive(1, 0, 0, 0, 0, 0, "reset1");
    check("reset.idle_white", int'(idle_white), 1);
    check("reset.result_valid", int'(result_valid), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      drive(0, tbl[i].cv, tbl[i].col, tbl[i].conf, tbl[i].wd, tbl[i].ack, t);
      check({t, ".t_valid"}, int'(result_valid), tbl[i].valid);
      check({t, ".t_color"}, int'(result_color), tbl[i].color);
      check({t, ".t_votes"}, int'(result_votes), tbl[i].votes);
      check({t, ".t_sum"},   int'(result_conf_sum), tbl[i].sum);
      check({t, ".t_end"},   int'(turn_end), tbl[i].te);
      check({t, ".t_abort"}, int'(turn_abort), tbl[i].ta);
      check({t, ".t_idle"},  int'(idle_white), tbl[i].idle);
    end

    // Timeout: R,G,R,G,B then 55 low-confidence frames -> 60 frames, abort.
    drive(0, 1, 1, 200, 0, 0, "to.r0");
    drive(0, 1, 2, 200, 0, 0, "to.g0");
    drive(0, 1, 1, 200, 0, 0, "to.r1");
    drive(0, 1, 2, 200, 0, 0, "to.g1");
    drive(0, 1, 3, 200, 0, 0, "to.b0");
    for (int i = 0; i < 55; i++) begin
      drive(0, 1, int'($urandom_range(1, 2)), 50, 0, 0, "to.none");
      check("to.no_early_abort", int'(turn_abort), 0);
      check("to.no_lock", int'(result_valid), 0);
    end
    idle_cycle("to.eval");
    check("to.abort_pulse", int'(turn_abort), 1);
    check("to.idle_white", int'(idle_white), 1);
    idle_cycle("to.after");
    check("to.abort_drop", int'(turn_abort), 0);

    // Coincident colour + white: push suppressed, white run advances.
    drive(0, 1, 1, 200, 0, 0, "co.r0");
    drive(0, 1, 1, 200, 0, 0, "co.r1");
    drive(0, 1, 1, 200, 1, 0, "co.rw");
    idle_cycle("co.i0");
    idle_cycle("co.i1");
    check("co.no_lock", int'(result_valid), 0);
    drive(0, 0, 0, 0, 1, 0, "co.w1");
    check("co.still_armed", int'(idle_white), 0);
    drive(0, 0, 0, 0, 1, 0, "co.w2");
    check("co.white_idle", int'(idle_white), 1);
    check("co.no_turn_end", int'(turn_end), 0);

    // Confidence 99 enters as NONE: never arms, and never locks once armed.
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 99, 0, 0, "lc.white");
    check("lc.stay_white", int'(idle_white), 1);
    drive(0, 1, 2, 100, 0, 0, "lc.arm");
    for (int i = 0; i < 6; i++) drive(0, 1, 1, 99, 0, 0, "lc.armed");
    check("lc.no_lock", int'(result_valid), 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, "lc.w");
    check("lc.back_white", int'(idle_white), 1);

    // Reset while LOCKED: reset values next cycle, no turn_end.
    drive(0, 1, 3, 150, 0, 0, "rs.b0");
    drive(0, 1, 3, 150, 0, 0, "rs.b1");
    drive(0, 1, 3, 150, 0, 0, "rs.b2");
    idle_cycle("rs.lock");
    check("rs.locked", int'(result_valid), 1);
    check("rs.sum", int'(result_conf_sum), 450);
    drive(1, 0, 0, 0, 0, 0, "rs.reset");
    check("rs.valid0", int'(result_valid), 0);
    check("rs.color0", int'(result_color), 0);
    check("rs.sum0", int'(result_conf_sum), 0);
    check("rs.idle1", int'(idle_white), 1);
    check("rs.no_end", int'(turn_end), 0);
    idle_cycle("rs.after");
    check("rs.no_end_after", int'(turn_end), 0);

    // Random traffic, mostly confident colours.
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 999) < 3),
            bit'($urandom_range(0, 99) < 45),
            int'($urandom_range(0, 3)),
            int'($urandom_range(60, 400)),
            bit'($urandom_range(0, 99) < 12),
            bit'($urandom_range(0, 99) < 30),
            "rnd.a");
    end
    // Random traffic, mostly low confidence so turns tend to time out.
    for (int i = 0; i < 3000; i++) begin
      drive(1'b0,
            bit'($urandom_range(0, 99) < 70),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 110)),
            bit'($urandom_range(0, 99) < 2),
            bit'($urandom_range(0, 99) < 30),
            "rnd.b");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
